// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: read-side controller for the audio sample FIFO feeding the FFT.
// Drains the FIFO (rd_en/rd_data/rd_empty), absorbs FIFO read latency with a small
// circular skid buffer, and presents a valid/ready stream with m_last on every
// FRAME_LEN-th sample. Start and stop are frame aligned.
//
// Ports:
//   clk, rst_n        clock (also FIFO rd_clk), asynchronous active-low reset
//   enable            level: start and keep streaming frames
//   rd_en             FIFO read enable (never high while rd_empty)
//   rd_data, rd_empty FIFO read data and empty flag
//   m_data, m_valid   stream sample and valid
//   m_ready           stream ready from the FFT
//   m_last            final sample of each frame
//   busy              FSM not in IDLE
//   underrun_clr/_cnt only with FIFO_FRAME_READER_UNDERRUN_CNT_EN defined: saturating
//                     count of starved mid-frame cycles, synchronous clear
module fifo_frame_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    input  logic [0:0]            underrun_clr,
    output logic [15:0]           underrun_cnt,
`endif
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [RD_LATENCY-1:0] lat_q, lat_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic [CNT_W-1:0]      out_cnt_q, issue_cnt_q;
    // Set once issue_cnt has wrapped into the next frame while output is still in
    // the current one; in FINISH this means the current frame is fully issued.
    logic                  issue_ahead_q;

    int unsigned inflight;
    logic        issue_ok, wr, accept, last_acc, issue_wrap, out_wrap, frame_fresh;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + 32'(lat_q[i]);
        end
    end

    assign issue_ok = ((state_q == RUN) || ((state_q == FINISH) && !issue_ahead_q)) &&
                      ((32'(occ_q) + inflight) < BUF_DEPTH);
    assign rd_en    = issue_ok & ~rd_empty;
    assign lat_d    = (lat_q << 1) | RD_LATENCY'(rd_en);
    assign wr       = lat_q[RD_LATENCY-1];

    assign m_valid  = (occ_q != '0);
    assign m_data   = m_valid ? buf_q[rd_ptr_q] : '0;
    assign m_last   = m_valid && (out_cnt_q == CNT_MAX);
    assign busy     = (state_q != IDLE);

    assign accept     = m_valid & m_ready;
    assign last_acc   = accept & m_last;
    assign issue_wrap = rd_en && (issue_cnt_q == CNT_MAX);
    assign out_wrap   = last_acc;
    // Nothing of the current frame has been issued yet.
    assign frame_fresh = (issue_cnt_q == '0) && !issue_ahead_q && (out_cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN: begin
                if (!enable) state_d = (last_acc || frame_fresh) ? IDLE : FINISH;
            end
            FINISH: begin
                if (last_acc && !enable) state_d = IDLE;
                else if (enable)         state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lat_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            out_cnt_q     <= '0;
            issue_cnt_q   <= '0;
            issue_ahead_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == IDLE) begin
                // Leaving the frame: drop anything buffered or still in flight.
                lat_q         <= '0;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                occ_q         <= '0;
                out_cnt_q     <= '0;
                issue_cnt_q   <= '0;
                issue_ahead_q <= 1'b0;
            end else begin
                lat_q <= lat_d;
                if (wr)     wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
                if (accept) rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
                if (wr && !accept)      occ_q <= occ_q + 1'b1;
                else if (!wr && accept) occ_q <= occ_q - 1'b1;
                if (rd_en)  issue_cnt_q <= issue_wrap ? '0 : issue_cnt_q + 1'b1;
                if (accept) out_cnt_q   <= out_wrap ? '0 : out_cnt_q + 1'b1;
                if (issue_wrap && !out_wrap)      issue_ahead_q <= 1'b1;
                else if (out_wrap && !issue_wrap) issue_ahead_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (wr && (state_d != IDLE)) buf_q[wr_ptr_q] <= rd_data;
    end

`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    logic        underrun_hit;

    assign underrun_hit = (state_q != IDLE) && ((out_cnt_q != '0) || (inflight != 0)) &&
                          rd_empty && (occ_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
        end else if (underrun_clr[0]) begin
            underrun_q <= '0;
        end else if (underrun_hit && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
module tb_fifo_frame_reader;
    localparam int FL = 1024;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic m_ready = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    // Shared FIFO model; instance 0 sees latency 1, instance 1 latency 2.
    logic [15:0] fifo_mem [0:16383];
    int          wptr = 0;
    int          rptr = 0;
    logic [15:0] rd_q1 = '0;
    logic [15:0] rd_q2 = '0;
    logic        fifo_empty;
    assign fifo_empty = (wptr == rptr);

    logic        rd_en0, rd_en1, m_valid0, m_valid1, m_last0, m_last1, busy0, busy1;
    logic [15:0] m_data0, m_data1;
    logic        a_rd_en, a_valid, a_last, a_busy;
    logic [15:0] a_data;
    assign a_rd_en = sel ? rd_en1 : rd_en0;
    assign a_valid = sel ? m_valid1 : m_valid0;
    assign a_last  = sel ? m_last1 : m_last0;
    assign a_busy  = sel ? busy1 : busy0;
    assign a_data  = sel ? m_data1 : m_data0;

`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    logic [0:0]  uclr = 1'b0;
    logic [15:0] ucnt0, ucnt1;
`endif

    fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(FL), .RD_LATENCY(1), .BUF_DEPTH(BD)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable & ~sel),
        .rd_en    (rd_en0),
        .rd_data  (rd_q1),
        .rd_empty (fifo_empty | sel),
        .m_data   (m_data0),
        .m_valid  (m_valid0),
        .m_ready  (m_ready),
        .m_last   (m_last0),
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
        .underrun_clr (uclr),
        .underrun_cnt (ucnt0),
`endif
        .busy     (busy0)
    );

    fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(FL), .RD_LATENCY(2), .BUF_DEPTH(BD)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable & sel),
        .rd_en    (rd_en1),
        .rd_data  (rd_q2),
        .rd_empty (fifo_empty | ~sel),
        .m_data   (m_data1),
        .m_valid  (m_valid1),
        .m_ready  (m_ready),
        .m_last   (m_last1),
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
        .underrun_clr (uclr),
        .underrun_cnt (ucnt1),
`endif
        .busy     (busy1)
    );

    always @(posedge clk) begin
        if (a_rd_en && !fifo_empty) begin
            rd_q1 <= fifo_mem[rptr];
            rptr  <= rptr + 1;
        end
        rd_q2 <= rd_q1;
    end

    // Stream monitor / scoreboard. Words carry their FIFO index, so the expected
    // next sample is simply a running index, resynchronised to the FIFO read
    // pointer when reset discards buffered data.
    int   exp_next = 0;
    int   pos = 0;
    int   outstanding = 0;
    int   beats = 0;
    int   lasts = 0;
    int   err_data = 0;
    int   err_last = 0;
    int   err_empty = 0;
    int   err_ovf = 0;
    int   err_stab = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_next    = rptr;
            pos         = 0;
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (a_rd_en && fifo_empty) err_empty++;
            if (a_rd_en) outstanding++;
            if (prev_stall && (!a_valid || a_data !== prev_data)) err_stab++;
            if (a_valid && (a_last !== (pos == FL - 1))) err_last++;
            if (!a_valid && a_last) err_last++;
            if (a_valid && m_ready) begin
                if (a_data !== exp_next[15:0]) err_data++;
                exp_next++;
                beats++;
                if (a_last) lasts++;
                pos = (pos + 1) % FL;
                outstanding--;
            end
            if (outstanding > BD) err_ovf++;
            prev_stall = a_valid && !m_ready;
            prev_data  = a_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wptr] = wptr[15:0];
            wptr++;
        end
    endtask

    // mode 0: ready high, 1: ready one cycle in three, 2: ready toggles
    task automatic run_until(input int target, input int max_cyc, input int mode,
                             output int ok, output int cyc);
        ok  = 0;
        cyc = 0;
        while (cyc < max_cyc && ok == 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (beats >= target) ok = 1;
            else if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = (cyc % 3 == 0);
            else m_ready = ~m_ready;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int ok);
        ok = 0;
        for (int i = 0; i < max_cyc && ok == 0; i++) begin
            @(posedge clk);
            #1;
            if (!a_busy) ok = 1;
        end
    endtask

    initial begin
        int ok, cyc, b0, l0, gap_valid;

        // Reset state
        #1;
        check("rst rd_en", a_rd_en, 0);
        check("rst m_valid", a_valid, 0);
        check("rst m_last", a_last, 0);
        check("rst m_data", a_data, 0);
        check("rst busy", a_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: full rate, two frames
        push(2048);
        m_ready = 1'b1;
        enable  = 1'b1;
        b0 = beats; l0 = lasts;
        run_until(b0 + 2048, 2100, 0, ok, cyc);
        check("t1 done", ok, 1);
        check("t1 beats", beats - b0, 2048);
        check("t1 lasts", lasts - l0, 2);
        check("t1 full rate", cyc <= 2056, 1);
        enable = 1'b0;
        wait_idle(20, ok);
        check("t1 idle", ok, 1);

        // 2: ready one cycle in three
        push(2048);
        enable = 1'b1;
        b0 = beats; l0 = lasts;
        run_until(b0 + 2048, 7000, 1, ok, cyc);
        check("t2 done", ok, 1);
        check("t2 lasts", lasts - l0, 2);
        check("t2 stable", err_stab, 0);
        check("t2 no overflow", err_ovf, 0);
        check("t2 data", err_data, 0);
        enable = 1'b0;
        wait_idle(20, ok);
        check("t2 idle", ok, 1);

        // 3: underflow gap mid-frame
        push(300);
        enable = 1'b1;
        b0 = beats; l0 = lasts;
        run_until(b0 + 300, 400, 0, ok, cyc);
        check("t3 first part", ok, 1);
        gap_valid = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (a_valid) gap_valid++;
        end
        check("t3 gap m_valid low", gap_valid, 0);
        push(724);
        run_until(b0 + 1024, 800, 0, ok, cyc);
        check("t3 done", ok, 1);
        check("t3 one last", lasts - l0, 1);
        check("t3 last errors", err_last, 0);
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
        check("t3 underrun >= 100", ucnt0 >= 16'd100, 1);
        uclr = 1'b1;
        @(posedge clk); #1;
        uclr = 1'b0;
        check("t3 underrun cleared", ucnt0, 0);
`endif
        enable = 1'b0;
        wait_idle(20, ok);
        check("t3 idle", ok, 1);

        // 4: enable dropped mid-frame
        push(2048);
        enable = 1'b1;
        b0 = beats; l0 = lasts;
        run_until(b0 + 500, 600, 0, ok, cyc);
        check("t4 reach 500", ok, 1);
        enable = 1'b0;
        wait_idle(1000, ok);
        check("t4 idle", ok, 1);
        check("t4 beats", beats - b0, 1024);
        check("t4 lasts", lasts - l0, 1);
        check("t4 rd_en", a_rd_en, 0);
        check("t4 busy", a_busy, 0);
        check("t4 fifo left", wptr - rptr, 1024);

        // 5: reset mid-frame
        push(1024);
        enable = 1'b1;
        b0 = beats;
        run_until(b0 + 600, 700, 0, ok, cyc);
        check("t5 reach 600", ok, 1);
        rst_n = 1'b0;
        #1;
        check("t5 rst rd_en", a_rd_en, 0);
        check("t5 rst m_valid", a_valid, 0);
        check("t5 rst m_last", a_last, 0);
        check("t5 rst m_data", a_data, 0);
        check("t5 rst busy", a_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b0 = beats; l0 = lasts;
        run_until(b0 + 10, 50, 0, ok, cyc);
        enable = 1'b0;
        for (int i = 0; i < 1100 && lasts == l0; i++) begin
            @(posedge clk); #1;
        end
        check("t5 last after 1024", beats - b0, 1024);
        wait_idle(20, ok);
        check("t5 idle", ok, 1);

        // 6: latency-2 instance, toggling ready then full rate
        sel = 1'b1;
        push(2048);
        enable = 1'b1;
        b0 = beats;
        run_until(b0 + 1000, 2600, 2, ok, cyc);
        check("t6 toggled", ok, 1);
        b0 = beats;
        run_until(b0 + 200, 260, 0, ok, cyc);
        check("t6 full rate", ok == 1 && cyc <= 204, 1);
        check("t6 data", err_data, 0);
        check("t6 last errors", err_last, 0);
        check("t6 no overflow", err_ovf, 0);
        check("t6 stable", err_stab, 0);
        check("rd_en while empty", err_empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
